alu_operand_pipe: RTL and testbench

- Registered, parametrised operand selector for the ALU second-operand path.
- Picks one of NSRC register-side sources, or an extended immediate, and produces a 1-cycle-latency output.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the execute stage can stall without losing operands.
- Sits between decode/forwarding and the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_operand_pipe_imm_extend.sv | 26 ++
 rtl/alu_operand_pipe.sv | 130 +++++++++++++
 tb/tb_alu_operand_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand path: default widths, immediate
// extension encodings and the operand-pipe occupancy states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_IMMW  = 16;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_HIGH = 2'b10,
        EXT_ILL  = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } occ_state_e;

endpackage

// File: rtl/alu_operand_pipe_imm_extend.sv
// Combinational immediate extender: zero, sign or shift-high placement of a
// raw IMMW-bit field into a WIDTH-bit operand, flagging the reserved mode.
module imm_extend
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned IMMW  = ALU_IMMW
) (
    input  logic [IMMW-1:0]  imm,
    input  logic [1:0]       ext_mode,
    output logic [WIDTH-1:0] ext_data,
    output logic             ext_illegal
);

    always_comb begin
        ext_data    = '0;
        ext_illegal = 1'b0;
        case (ext_mode_e'(ext_mode))
            EXT_ZERO: ext_data = {{(WIDTH-IMMW){1'b0}}, imm};
            EXT_SIGN: ext_data = {{(WIDTH-IMMW){imm[IMMW-1]}}, imm};
            EXT_HIGH: ext_data = {imm, {(WIDTH-IMMW){1'b0}}};
            default:  ext_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_operand_pipe.sv
// ALU second-operand selector: picks a source or extended immediate and
// delivers it through a 2-entry (OUT + SKID) valid/ready pipeline stage.
module alu_operand_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned NSRC  = 3,
    parameter int unsigned IMMW  = ALU_IMMW,
    parameter int unsigned SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [IMMW-1:0]       imm,
    input  logic [1:0]            ext_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err
);

    occ_state_e       state_q, state_d;
    logic             ready_d;
    logic             in_xfer, out_xfer;
    logic             load_out_new, load_out_skid, load_skid;
    logic [WIDTH-1:0] ext_data, new_data, skid_data;
    logic             ext_illegal, new_err, skid_err;

    imm_extend #(
        .WIDTH (WIDTH),
        .IMMW  (IMMW)
    ) u_imm_extend (
        .imm         (imm),
        .ext_mode    (ext_mode),
        .ext_data    (ext_data),
        .ext_illegal (ext_illegal)
    );

    // Illegal requests still occupy a slot; they carry zero data and err=1.
    always_comb begin
        new_data = '0;
        new_err  = 1'b0;
        if (sel == SELW'(NSRC)) begin
            new_err  = ext_illegal;
            new_data = ext_illegal ? '0 : ext_data;
        end else if (sel > SELW'(NSRC)) begin
            new_err = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NSRC; k++) begin
                if (sel == SELW'(k)) new_data = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d      = ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_new = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        ready_d   = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_data <= new_data;
                out_err  <= new_err;
            end else if (load_out_skid) begin
                out_data <= skid_data;
                out_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= new_data;
                skid_err  <= new_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Self-checking bench for alu_operand_pipe: a FIFO reference model of
// formed operands is compared against the DUT every cycle.
module tb_alu_operand_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0]  sel, ext_mode;
    logic [95:0] src_data;
    logic [15:0] imm;
    logic [31:0] out_data;

    logic        in_valid2, in_ready2, out_valid2, out_err2;
    logic [1:0]  sel2, ext_mode2;
    logic [63:0] src_data2;
    logic [15:0] imm2;
    logic [31:0] out_data2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [32:0] model_q[$];
    bit          started = 0;
    bit          rst_seen = 0;
    int unsigned outs = 0;
    int unsigned ready_drops = 0;

    always #5 clk = ~clk;

    alu_operand_pipe #(.WIDTH(32), .NSRC(3), .IMMW(16), .SELW(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_data(src_data), .imm(imm), .ext_mode(ext_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    alu_operand_pipe #(.WIDTH(32), .NSRC(2), .IMMW(16), .SELW(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .sel(sel2), .src_data(src_data2), .imm(imm2), .ext_mode(ext_mode2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_data(out_data2), .out_err(out_err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {err, data} the operand should carry, straight from the selection rules.
    function automatic logic [32:0] ref_op(input logic [1:0] s, input logic [95:0] src,
                                           input logic [15:0] im, input logic [1:0] ex);
        logic [31:0] d;
        if (s < 2'd3) return {1'b0, src[s*32 +: 32]};
        case (ex)
            2'd0: d = 32'(im);
            2'd1: d = 32'($signed(im));
            2'd2: d = 32'(im) << 16;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, d};
    endfunction

    // One clock: check outputs against the model, apply inputs, advance model.
    task automatic step(input logic v, input logic [1:0] s, input logic [95:0] src,
                        input logic [15:0] im, input logic [1:0] ex,
                        input logic ordy, input logic r);
        logic ix, ox;
        if (started) begin
            if (rst_seen) begin
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_out_data", 64'(out_data), 64'd0);
                check("rst_out_err", 64'(out_err), 64'd0);
            end else begin
                check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
                check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
                if (in_ready !== 1'b1) ready_drops++;
                if (model_q.size() > 0)
                    check("out_operand", 64'({out_err, out_data}), 64'(model_q[0]));
            end
        end
        in_valid = v; sel = s; src_data = src; imm = im; ext_mode = ex;
        out_ready = ordy; rst = r;
        if (r) begin
            model_q.delete();
            rst_seen = 1;
        end else begin
            ix = v && in_ready;
            ox = out_valid && ordy;
            if (ox && model_q.size() > 0) begin
                void'(model_q.pop_front());
                outs++;
            end
            if (ix) model_q.push_back(ref_op(s, src, im, ex));
            rst_seen = 0;
        end
        started = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'd0, 96'h0, 16'h0, 2'd0, ordy, 1'b0);
    endtask

    initial begin
        logic [95:0] src;
        int unsigned o0, d0;
        in_valid2 = 0; sel2 = 0; ext_mode2 = 0; src_data2 = '0; imm2 = 0;
        #1;
        step(1'b0, 2'd0, 96'h0, 16'h0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 96'h0, 16'h0, 2'd0, 1'b1, 1'b1);
        idle(1'b1);

        // single operand from source 0
        step(1'b1, 2'd0, 96'h0000_0000_0000_0000_0000_00AA, 16'h0, 2'd0, 1'b1, 1'b0);
        check("single_data", 64'(out_data), 64'h0000_00AA);
        check("single_valid", 64'(out_valid), 64'd1);
        idle(1'b1);

        // immediate modes back to back
        step(1'b1, 2'd3, 96'h0, 16'hFFFE, 2'd0, 1'b1, 1'b0);
        check("imm_zero", 64'(out_data), 64'h0000_FFFE);
        step(1'b1, 2'd3, 96'h0, 16'hFFFE, 2'd1, 1'b1, 1'b0);
        check("imm_sign", 64'(out_data), 64'hFFFF_FFFE);
        step(1'b1, 2'd3, 96'h0, 16'hFFFE, 2'd2, 1'b1, 1'b0);
        check("imm_high", 64'(out_data), 64'hFFFE_0000);
        idle(1'b1);

        // backpressure: A, B, then C held while stalled
        step(1'b1, 2'd1, {32'h0, 32'hAAAA_0001, 32'h0}, 16'h0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd2, {32'hBBBB_0002, 64'h0}, 16'h0, 2'd0, 1'b0, 1'b0);
        check("skid_hold_a", 64'(out_data), 64'hAAAA_0001);
        check("skid_full_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'd3, 96'h0, 16'h0C0C, 2'd0, 1'b0, 1'b0);
        check("skid_still_a", 64'(out_data), 64'hAAAA_0001);
        for (int i = 0; i < 2; i++)
            step(1'b1, 2'd3, 96'h0, 16'h0C0C, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("skid_drained", 64'(out_valid), 64'd0);

        // illegal requests, then a legal one
        step(1'b1, 2'd3, 96'h0, 16'h1234, 2'd3, 1'b1, 1'b0);
        check("ill_ext_err", 64'({out_err, out_data}), {31'h0, 1'b1, 32'h0});
        step(1'b1, 2'd2, 96'h5, 16'h1234, 2'd3, 1'b1, 1'b0);
        check("legal_clears_err", 64'(out_err), 64'd0);
        idle(1'b1);

        // NSRC=2 build: out-of-range sel, reserved mode, then legal
        in_valid2 = 1; sel2 = 2'd3; ext_mode2 = 2'd0; imm2 = 16'h7777; src_data2 = {32'h22, 32'h11};
        idle(1'b1);
        check("n2_sel_err", 64'({out_valid2, out_err2, out_data2}), {30'h0, 2'b11, 32'h0});
        sel2 = 2'd2; ext_mode2 = 2'd3;
        idle(1'b1);
        check("n2_ext_err", 64'({out_valid2, out_err2, out_data2}), {30'h0, 2'b11, 32'h0});
        ext_mode2 = 2'd0;
        idle(1'b1);
        check("n2_imm_ok", 64'({out_valid2, out_err2, out_data2}), {30'h0, 2'b10, 32'h7777});
        sel2 = 2'd1;
        idle(1'b1);
        check("n2_src1", 64'({out_valid2, out_err2, out_data2}), {30'h0, 2'b10, 32'h22});
        in_valid2 = 0;
        idle(1'b1);

        // mid-operation reset from TWO
        step(1'b1, 2'd0, 96'h1111, 16'h0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 96'h2222, 16'h0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 96'h3333, 16'h0, 2'd0, 1'b0, 1'b1);
        idle(1'b1);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        idle(1'b1);

        // streaming: 16 back-to-back with out_ready high
        o0 = outs; d0 = ready_drops;
        for (int i = 0; i < 16; i++) begin
            src = {$urandom, $urandom, $urandom};
            step(1'b1, 2'($urandom_range(0, 2)), src, 16'($urandom), 2'd0, 1'b1, 1'b0);
        end
        idle(1'b1);
        check("stream_outputs", 64'(outs - o0), 64'd16);
        check("stream_ready_drops", 64'(ready_drops - d0), 64'd0);

        // randomized traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            src = {$urandom, $urandom, $urandom};
            step(1'($urandom_range(0, 1)), 2'($urandom), src, 16'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("final_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
